apb_master_nslv: RTL and testbench
==================================

APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

Interface
REQ-001 SHALL have parameter ADDR_W, 9, command address width including slave-select bits.
REQ-002 SHALL have parameter DATA_W, 8, data width.
REQ-003 SHALL have parameter NUM_SLV, 2, number of APB slaves (2..16).
REQ-004 SHALL have parameter TIMEOUT, 16, maximum ACCESS cycles before abort (>=2).
REQ-005 SHALL derive SEL_W = max(1, clog2(NUM_SLV)) and PA_W = ADDR_W-SEL_W.
REQ-006 SHALL have port pclk input 1, clock; all logic on rising edge.
REQ-007 SHALL have port presetn input 1, asynchronous active-low reset.
REQ-008 SHALL have port transfer input 1, command request.
REQ-009 SHALL have port read_write input 1, 1=read, 0=write.
REQ-010 SHALL have port apb_read_paddr input ADDR_W, read address.
REQ-011 SHALL have port apb_write_paddr input ADDR_W, write address.
REQ-012 SHALL have port apb_write_data input DATA_W, write data.
REQ-013 SHALL have port cmd_ready output 1, command accepted when transfer&&cmd_ready.
REQ-014 SHALL have port apb_read_data_out output DATA_W, last completed read data.
REQ-015 SHALL have port rsp_valid output 1, one-cycle completion pulse; rsp_err output 1, error qualifier valid with rsp_valid.
REQ-016 SHALL have APB ports psel output NUM_SLV, penable output 1, pwrite output 1, paddr output PA_W, pwdata output DATA_W.
REQ-017 SHALL have slave-return ports prdata input NUM_SLV*DATA_W (slave i at [i*DATA_W+:DATA_W]), pready input NUM_SLV, pslverr input NUM_SLV.

Function
REQ-018 SHALL implement FSM IDLE, SETUP, ACCESS; IDLE->SETUP on accepted command with valid slave index.
REQ-019 SHALL select address from apb_read_paddr if read_write=1 else apb_write_paddr; slave index = addr[ADDR_W-1 -: SEL_W]; paddr = addr[PA_W-1:0].
REQ-020 SHALL register paddr, pwrite, pwdata, slave index at acceptance and hold them stable through SETUP and ACCESS.
REQ-021 SHALL assert psel[index] alone in SETUP and ACCESS; penable only in ACCESS; SETUP lasts exactly one cycle.
REQ-022 SHALL complete ACCESS in the cycle selected pready=1; rsp_valid pulses next cycle with rsp_err = selected pslverr.
REQ-023 SHALL on read completion without pslverr load apb_read_data_out with selected prdata; value held otherwise (writes, errors do not change it).
REQ-024 SHALL drive cmd_ready=1 in IDLE and in ACCESS when selected pready=1; 0 otherwise.
REQ-025 SHALL on command accepted in completing ACCESS go directly to SETUP (back-to-back, no IDLE cycle), else IDLE.
REQ-026 SHALL count ACCESS wait cycles; TIMEOUT cycles with pready=0 -> deassert psel/penable, rsp_valid=1, rsp_err=1, return IDLE.
REQ-027 SHALL treat slave index >= NUM_SLV as decode error: no psel asserted, rsp_valid=1 and rsp_err=1 one cycle after acceptance, remain IDLE.
REQ-028 SHALL ignore pready/pslverr/prdata of non-selected slaves and all slave inputs outside ACCESS.
REQ-029 SHALL ignore transfer when cmd_ready=0 (no queueing).

Reset
REQ-030 SHALL on presetn=0 asynchronously force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_err=0, apb_read_data_out=0, wait counter=0.
REQ-031 SHALL abandon an in-flight transfer on reset with no rsp_valid generated; cmd_ready=1 one cycle after presetn release.

Structure
REQ-032 SHALL place FSM state enum, RD/WR encoding constants and default parameter values in package apb_nslv_pkg.
REQ-033 SHALL isolate index decode and prdata/pready/pslverr muxing in sub-module apb_slv_decode.

Verification (NUM_SLV=2, ADDR_W=9, DATA_W=8, TIMEOUT=16)
REQ-034 Write 0x5A to addr 0x105, slave1 pready=1 -> psel=2'b10 SETUP 1 cycle, ACCESS 1 cycle, paddr=0x05, rsp_valid, rsp_err=0.
REQ-035 Read addr 0x033, slave0 pready low 3 cycles, prdata=0xC3 -> penable held 4 cycles, apb_read_data_out=0xC3.
REQ-036 Two reads held transfer=1 -> second SETUP immediately follows first ACCESS, no IDLE cycle.
REQ-037 Write with slave0 pready stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, psel=0.
REQ-038 Read with pslverr=1, prdata=0xFF -> rsp_err=1, apb_read_data_out unchanged.
REQ-039 presetn low during ACCESS -> psel/penable 0 same cycle, no rsp_valid; NUM_SLV=3 addr index 3 -> decode error, no psel.

Source files
------------

// File: rtl/apb_nslv_pkg.sv
// Shared types and defaults for the multi-slave APB master.
// Holds the FSM state encoding, read/write command encoding and parameter defaults.
package apb_nslv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_NUM_SLV = 2;
    localparam int DEF_TIMEOUT = 16;

    function automatic int sel_width(input int num_slv);
        return (num_slv > 2) ? $clog2(num_slv) : 1;
    endfunction

endpackage

// File: rtl/apb_slv_decode.sv
// Slave index decode: range check of the incoming command index, one-hot select of the
// latched index, and mux of the selected slave's return signals (only while in ACCESS).
module apb_slv_decode #(
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int SEL_W   = 1
) (
    input  logic [SEL_W-1:0]          cmd_idx,
    output logic                      cmd_idx_ok,
    input  logic [SEL_W-1:0]          cur_idx,
    input  logic                      access,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic [NUM_SLV-1:0]        psel_vec,
    output logic [DATA_W-1:0]         sel_prdata,
    output logic                      sel_pready,
    output logic                      sel_pslverr
);

    assign cmd_idx_ok = ({{(32-SEL_W){1'b0}}, cmd_idx} < 32'(NUM_SLV));

    always_comb begin
        psel_vec    = '0;
        sel_prdata  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (cur_idx == SEL_W'(i)) begin
                psel_vec[i] = 1'b1;
                if (access) begin
                    sel_prdata  = prdata[i*DATA_W +: DATA_W];
                    sel_pready  = pready[i];
                    sel_pslverr = pslverr[i];
                end
            end
        end
    end

endmodule

// File: rtl/apb_master_nslv.sv
// APB master fanning one command port out to NUM_SLV slaves, with wait-state timeout
// and decode-error reporting for slave indices beyond NUM_SLV.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | ready for a command; psel/penable low
// ST_SETUP  | psel of latched slave high for exactly one cycle
// ST_ACCESS | psel+penable high until pready or the wait counter expires
module apb_master_nslv
    import apb_nslv_pkg::*;
#(
    parameter int  ADDR_W  = DEF_ADDR_W,
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  NUM_SLV = DEF_NUM_SLV,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    localparam int SEL_W   = sel_width(NUM_SLV),
    localparam int PA_W    = ADDR_W - SEL_W
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      transfer,
    input  logic                      read_write,
    input  logic [ADDR_W-1:0]         apb_read_paddr,
    input  logic [ADDR_W-1:0]         apb_write_paddr,
    input  logic [DATA_W-1:0]         apb_write_data,
    output logic                      cmd_ready,
    output logic [DATA_W-1:0]         apb_read_data_out,
    output logic                      rsp_valid,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [PA_W-1:0]           paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT);

    apb_state_e        state, state_nx;
    logic [ADDR_W-1:0] cmd_addr;
    logic [SEL_W-1:0]  cmd_idx, cur_idx;
    logic              cmd_idx_ok;
    logic [CNT_W-1:0]  wait_cnt;
    logic              err_pend;
    logic              load, done, tmo, bad_accept, idle_err;
    logic [NUM_SLV-1:0] psel_vec;
    logic [DATA_W-1:0] sel_prdata;
    logic              sel_pready, sel_pslverr;

    assign cmd_addr = (read_write == RW_READ) ? apb_read_paddr : apb_write_paddr;
    assign cmd_idx  = cmd_addr[ADDR_W-1 -: SEL_W];

    apb_slv_decode #(
        .DATA_W  (DATA_W),
        .NUM_SLV (NUM_SLV),
        .SEL_W   (SEL_W)
    ) u_decode (
        .cmd_idx     (cmd_idx),
        .cmd_idx_ok  (cmd_idx_ok),
        .cur_idx     (cur_idx),
        .access      (state == ST_ACCESS),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .psel_vec    (psel_vec),
        .sel_prdata  (sel_prdata),
        .sel_pready  (sel_pready),
        .sel_pslverr (sel_pslverr)
    );

    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        penable    = 1'b0;
        load       = 1'b0;
        done       = 1'b0;
        tmo        = 1'b0;
        bad_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (transfer) begin
                    if (cmd_idx_ok) begin
                        load     = 1'b1;
                        state_nx = ST_SETUP;
                    end else begin
                        bad_accept = 1'b1;
                    end
                end
            end
            ST_SETUP: state_nx = ST_ACCESS;
            ST_ACCESS: begin
                penable = 1'b1;
                if (sel_pready) begin
                    cmd_ready = 1'b1;
                    done      = 1'b1;
                    state_nx  = ST_IDLE;
                    if (transfer && cmd_idx_ok) begin
                        load     = 1'b1;
                        state_nx = ST_SETUP;
                    end else if (transfer) begin
                        bad_accept = 1'b1;
                    end
                end else if (wait_cnt == '0) begin
                    tmo      = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign psel = (state == ST_SETUP || state == ST_ACCESS) ? psel_vec : '0;

    // A decode error accepted in a completing ACCESS would collide with that completion's
    // response, so it is deferred one cycle through err_pend.
    assign idle_err = (state == ST_IDLE) && (bad_accept || err_pend);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state             <= ST_IDLE;
            paddr             <= '0;
            pwrite            <= 1'b0;
            pwdata            <= '0;
            cur_idx           <= '0;
            wait_cnt          <= '0;
            err_pend          <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_err           <= 1'b0;
            apb_read_data_out <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                paddr   <= cmd_addr[PA_W-1:0];
                pwrite  <= (read_write == RW_WRITE);
                pwdata  <= apb_write_data;
                cur_idx <= cmd_idx;
            end
            if (state == ST_SETUP)
                wait_cnt <= CNT_W'(TIMEOUT - 1);
            else if (state == ST_ACCESS && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            err_pend  <= (state == ST_ACCESS && bad_accept) ||
                         (state == ST_IDLE && err_pend && bad_accept);
            rsp_valid <= done || tmo || idle_err;
            rsp_err   <= done ? sel_pslverr : (tmo || idle_err);
            if (done && !pwrite && !sel_pslverr)
                apb_read_data_out <= sel_prdata;
        end
    end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Directed bench for apb_master_nslv: 2-slave instance for the transfer scenarios and
// a 3-slave instance for decode-error handling.
module tb_apb_master_nslv;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;

    logic        transfer = 1'b0, read_write = 1'b0;
    logic [8:0]  rd_addr = '0, wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        cmd_ready, rsp_valid, rsp_err, penable, pwrite;
    logic [7:0]  rdata_out, pwdata, paddr;
    logic [1:0]  psel;
    logic [15:0] prdata = '0;
    logic [1:0]  pready = '0, pslverr = '0;

    logic        transfer_3 = 1'b0, read_write_3 = 1'b0;
    logic [8:0]  rd_addr_3 = '0, wr_addr_3 = '0;
    logic [7:0]  wr_data_3 = '0;
    logic        cmd_ready_3, rsp_valid_3, rsp_err_3, penable_3, pwrite_3;
    logic [7:0]  rdata_out_3, pwdata_3;
    logic [6:0]  paddr_3;
    logic [2:0]  psel_3;
    logic [23:0] prdata_3 = '0;
    logic [2:0]  pready_3 = '0, pslverr_3 = '0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 pclk = ~pclk;

    apb_master_nslv #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn), .transfer(transfer), .read_write(read_write),
        .apb_read_paddr(rd_addr), .apb_write_paddr(wr_addr), .apb_write_data(wr_data),
        .cmd_ready(cmd_ready), .apb_read_data_out(rdata_out), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_master_nslv #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(16)) dut_3 (
        .pclk(pclk), .presetn(presetn), .transfer(transfer_3), .read_write(read_write_3),
        .apb_read_paddr(rd_addr_3), .apb_write_paddr(wr_addr_3), .apb_write_data(wr_data_3),
        .cmd_ready(cmd_ready_3), .apb_read_data_out(rdata_out_3), .rsp_valid(rsp_valid_3),
        .rsp_err(rsp_err_3), .psel(psel_3), .penable(penable_3), .pwrite(pwrite_3),
        .paddr(paddr_3), .pwdata(pwdata_3), .prdata(prdata_3), .pready(pready_3),
        .pslverr(pslverr_3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        int n_acc;

        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", psel, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_paddr", paddr, 0);

        // write 0x5A to 0x105 -> slave 1, zero wait states
        transfer = 1; read_write = 0; wr_addr = 9'h105; wr_data = 8'h5A; pready = 2'b10;
        @(negedge pclk);
        transfer = 0;
        check("wr_setup_psel", psel, 2'b10);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_cmd_ready", cmd_ready, 0);
        check("wr_paddr", paddr, 8'h05);
        check("wr_pwrite", pwrite, 1);
        check("wr_pwdata", pwdata, 8'h5A);
        @(negedge pclk);
        check("wr_access_psel", psel, 2'b10);
        check("wr_access_penable", penable, 1);
        check("wr_access_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_done_psel", psel, 0);
        check("wr_rdata_kept", rdata_out, 0);
        @(negedge pclk);
        check("wr_rsp_pulse", rsp_valid, 0);

        // read 0x033 -> slave 0, three wait states; slave 1 pready must be ignored
        prdata = {8'h77, 8'hC3}; pready = 2'b00;
        transfer = 1; read_write = 1; rd_addr = 9'h033;
        @(negedge pclk);
        transfer = 0;
        check("rd_setup_psel", psel, 2'b01);
        check("rd_paddr", paddr, 8'h33);
        check("rd_pwrite", pwrite, 0);
        pready = 2'b10;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (penable) n_acc++;
            if (i < 3) check("rd_wait_cmd_ready", cmd_ready, 0);
            if (i == 3) pready = 2'b01;
        end
        @(negedge pclk);
        pready = 2'b00;
        check("rd_penable_cycles", n_acc, 4);
        check("rd_done_penable", penable, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_data", rdata_out, 8'hC3);

        // read with pslverr from slave 1: error response, read data untouched
        prdata = {8'hFF, 8'h00}; pready = 2'b10; pslverr = 2'b10;
        transfer = 1; read_write = 1; rd_addr = 9'h1AA;
        @(negedge pclk);
        transfer = 0;
        check("err_psel", psel, 2'b10);
        @(negedge pclk);
        @(negedge pclk);
        check("err_rsp_valid", rsp_valid, 1);
        check("err_rsp_err", rsp_err, 1);
        check("err_rdata_kept", rdata_out, 8'hC3);
        pslverr = 2'b00;

        // back-to-back reads with transfer held high
        prdata = {8'h22, 8'h11}; pready = 2'b01;
        transfer = 1; read_write = 1; rd_addr = 9'h010;
        @(negedge pclk);
        check("b2b_setup1_psel", psel, 2'b01);
        check("b2b_setup1_penable", penable, 0);
        @(negedge pclk);
        check("b2b_access1_cmd_ready", cmd_ready, 1);
        rd_addr = 9'h120; pready = 2'b11;
        @(negedge pclk);
        transfer = 0;
        check("b2b_setup2_psel", psel, 2'b10);
        check("b2b_setup2_penable", penable, 0);
        check("b2b_setup2_paddr", paddr, 8'h20);
        check("b2b_rsp1_valid", rsp_valid, 1);
        check("b2b_rdata1", rdata_out, 8'h11);
        @(negedge pclk);
        check("b2b_access2_penable", penable, 1);
        @(negedge pclk);
        check("b2b_rsp2_valid", rsp_valid, 1);
        check("b2b_rdata2", rdata_out, 8'h22);
        check("b2b_done_psel", psel, 0);

        // write to slave 0 with pready stuck low -> timeout; stray transfer ignored
        pready = 2'b00;
        transfer = 1; read_write = 0; wr_addr = 9'h0F0; wr_data = 8'h99;
        @(negedge pclk);
        transfer = 0;
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (!penable) break;
            n_acc++;
            if (n_acc == 2) begin
                transfer = 1; wr_addr = 9'h1FF; wr_data = 8'h00;
            end else begin
                transfer = 0;
            end
        end
        check("tmo_access_cycles", n_acc, 16);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_psel", psel, 0);
        check("tmo_paddr_held", paddr, 8'hF0);
        check("tmo_pwdata_held", pwdata, 8'h99);
        @(negedge pclk);
        check("tmo_rsp_pulse", rsp_valid, 0);

        // reset during ACCESS
        transfer = 1; read_write = 0; wr_addr = 9'h101; wr_data = 8'h3C;
        @(negedge pclk);
        transfer = 0;
        @(negedge pclk);
        check("rst_mid_penable_before", penable, 1);
        #2 presetn = 0;
        #1;
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable", penable, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        @(negedge pclk);
        presetn = 1;
        @(negedge pclk);
        check("rst_rel_cmd_ready", cmd_ready, 1);
        check("rst_rel_rsp_valid", rsp_valid, 0);
        check("rst_rel_rdata", rdata_out, 0);
        check("rst_rel_pwrite", pwrite, 0);
        @(negedge pclk);
        check("rst_rel_no_rsp", rsp_valid, 0);

        // 3-slave instance: index 3 is a decode error
        transfer_3 = 1; read_write_3 = 0; wr_addr_3 = 9'h180; wr_data_3 = 8'hAB;
        @(negedge pclk);
        transfer_3 = 0;
        check("dec_psel", psel_3, 0);
        check("dec_rsp_valid", rsp_valid_3, 1);
        check("dec_rsp_err", rsp_err_3, 1);
        check("dec_cmd_ready", cmd_ready_3, 1);
        @(negedge pclk);
        check("dec_rsp_pulse", rsp_valid_3, 0);

        // 3-slave instance: valid index 2
        pready_3 = 3'b100;
        transfer_3 = 1; read_write_3 = 0; wr_addr_3 = 9'h105;
        @(negedge pclk);
        transfer_3 = 0;
        check("s2_psel", psel_3, 3'b100);
        check("s2_paddr", paddr_3, 7'h05);
        @(negedge pclk);
        @(negedge pclk);
        check("s2_rsp_valid", rsp_valid_3, 1);
        check("s2_rsp_err", rsp_err_3, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
